// File: rtl/xor_descrambler.sv
// Self-synchronous 1 + x^14 + x^15 descrambler with a registered valid/ready output and lock tag.
// Optional XOR_DESCRAMBLER_BYPASS_EN adds a bypass input that forwards beats unchanged.
module xor_descrambler #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sync_clear,
`ifdef XOR_DESCRAMBLER_BYPASS_EN
   input  logic              bypass,
`endif
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_locked
);

   localparam int         HIST_W  = 15;
   localparam logic [3:0] CNT_MAX = 4'd15;

   logic [HIST_W-1:0] s_q;
   logic [HIST_W-1:0] s_next;
   logic [3:0]        cnt_q;
   logic [3:0]        cnt_next;
   logic [DATA_W-1:0] d_bits;
   logic [DATA_W-1:0] out_data_next;
   logic              out_locked_next;
   logic              accept;

   assign in_ready = !sync_clear && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin : descramble
      logic [HIST_W-1:0] st;
      // NOTE: blocking assignments chain each bit's updated history into the next bit of the same beat.
      st     = s_q;
      d_bits = '0;
      for (int k = 0; k < DATA_W; k++) begin
         d_bits[k] = in_data[k] ^ st[13] ^ st[14];
         st        = {st[HIST_W-2:0], in_data[k]};
      end
      s_next = st;
   end

   always_comb begin : lock_count
      int sum;
      sum      = int'(cnt_q) + DATA_W;
      cnt_next = (sum >= int'(CNT_MAX)) ? CNT_MAX : sum[3:0];
   end

   always_comb begin
      out_data_next   = d_bits;
      out_locked_next = (cnt_q == CNT_MAX);
`ifdef XOR_DESCRAMBLER_BYPASS_EN
      if (bypass) begin
         out_data_next   = in_data;
         out_locked_next = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q        <= '0;
         cnt_q      <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_locked <= 1'b0;
      end else begin
         // sync_clear also blocks acceptance, so the two branches never compete for a beat.
         if (sync_clear) begin
            s_q   <= '0;
            cnt_q <= '0;
         end else if (accept) begin
            s_q   <= s_next;
            cnt_q <= cnt_next;
         end

         if (accept) begin
            out_data   <= out_data_next;
            out_locked <= out_locked_next;
            out_valid  <= 1'b1;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_xor_descrambler.sv
// Scoreboard bench for xor_descrambler (DATA_W = 8): directed steps, round trip through a
// reference scrambler, backpressure, sync_clear, async reset and (when enabled) bypass.
module tb_xor_descrambler;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] data;
      logic         locked;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         sync_clear = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic         out_locked;
   logic         byp = 1'b0;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb_q[$];
   bit   hist[$];

   xor_descrambler #(.DATA_W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .sync_clear (sync_clear),
`ifdef XOR_DESCRAMBLER_BYPASS_EN
      .bypass     (byp),
`endif
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_locked (out_locked)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected output from the bit-stream form d[k] = c[k] ^ c[k-14] ^ c[k-15], zero before start.
   task automatic model_push(input logic [W-1:0] data, input bit use_exp,
                             input logic [W-1:0] ed, input logic el);
      exp_t e;
      int   n;
      e.locked = (hist.size() >= 15);
      for (int k = 0; k < W; k++) begin
         hist.push_back(data[k]);
         n = hist.size();
         e.data[k] = hist[n-1] ^ ((n >= 15) ? hist[n-15] : 1'b0) ^ ((n >= 16) ? hist[n-16] : 1'b0);
      end
      while (hist.size() > 64) void'(hist.pop_front());
      if (byp) begin
         e.data   = data;
         e.locked = 1'b1;
      end
      if (use_exp) begin
         e.data   = ed;
         e.locked = el;
      end
      sb_q.push_back(e);
   endtask

   task automatic send(input logic [W-1:0] data, input bit use_exp,
                       input logic [W-1:0] ed, input logic el);
      in_data  = data;
      in_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            model_push(data, use_exp, ed, el);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      check("send_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int t = 0; t < 50 && sb_q.size() != 0; t++) begin
         @(posedge clk);
         #1;
      end
      check("drain_empty", sb_q.size(), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL spurious_beat: observed %h expected no beat", out_data);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("out_data", {24'b0, out_data}, {24'b0, e.data});
            check("out_locked", {31'b0, out_locked}, {31'b0, e.locked});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [14:0]  tx;
      logic [W-1:0] pay;
      logic [W-1:0] scr;
      logic         c;
      int           c0;

      // Reset values
      #12;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", {24'b0, out_data}, 32'd0);
      check("rst_out_locked", {31'b0, out_locked}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Zero-history passthrough
      send(8'h01, 1, 8'h01, 1'b0);
      send(8'h00, 1, 8'hC0, 1'b0);
      send(8'h00, 1, 8'h00, 1'b1);
      drain();

      // Round trip through a reference scrambler with random seed
      sync_clear = 1'b1;
      @(posedge clk);
      #1;
      sync_clear = 1'b0;
      hist.delete();
      tx = 15'($urandom);
      for (int b = 0; b < 1000; b++) begin
         pay = W'($urandom);
         for (int k = 0; k < W; k++) begin
            c      = pay[k] ^ tx[13] ^ tx[14];
            scr[k] = c;
            tx     = {tx[13:0], c};
         end
         if (b < 2) send(scr, 0, '0, 1'b0);
         else       send(scr, 1, pay, 1'b1);
      end
      drain();

      // Backpressure: one beat held, next beat stalled for 5 cycles
      out_ready = 1'b0;
      send(8'h3C, 0, '0, 1'b0);
      in_data  = 8'h96;
      in_valid = 1'b1;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         check("bp_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_out_valid", {31'b0, out_valid}, 32'd1);
         check("bp_hold", {24'b0, out_data}, {24'b0, sb_q[0].data});
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      c0 = cyc;
      send(8'h96, 0, '0, 1'b0);
      send(8'h11, 0, '0, 1'b0);
      send(8'hE7, 0, '0, 1'b0);
      send(8'h42, 0, '0, 1'b0);
      check("throughput_cycles", cyc - c0, 32'd4);
      drain();

      // sync_clear mid-stream with a pending valid input
      send(8'h5D, 0, '0, 1'b0);
      in_data    = 8'h77;
      in_valid   = 1'b1;
      sync_clear = 1'b1;
      @(negedge clk);
      check("clr_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      sync_clear = 1'b0;
      in_valid   = 1'b0;
      hist.delete();
      send(8'h01, 1, 8'h01, 1'b0);
      send(8'h00, 1, 8'hC0, 1'b0);
      send(8'h00, 1, 8'h00, 1'b1);
      drain();

      // Async reset while a beat is stalled
      out_ready = 1'b0;
      send(8'h5A, 0, '0, 1'b0);
      #2;
      check("ar_pre_valid", {31'b0, out_valid}, 32'd1);
      reset = 1'b1;
      #1;
      check("ar_out_valid", {31'b0, out_valid}, 32'd0);
      check("ar_out_data", {24'b0, out_data}, 32'd0);
      check("ar_out_locked", {31'b0, out_locked}, 32'd0);
      sb_q.delete();
      hist.delete();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("ar_in_ready", {31'b0, in_ready}, 32'd1);
      send(8'h01, 1, 8'h01, 1'b0);
      send(8'h00, 1, 8'hC0, 1'b0);
      drain();

`ifdef XOR_DESCRAMBLER_BYPASS_EN
      // Bypass forwards beats unchanged; history keeps updating for a seamless return
      send(8'h00, 0, '0, 1'b0);
      byp = 1'b1;
      send(8'hA5, 1, 8'hA5, 1'b1);
      send(8'h3E, 0, '0, 1'b0);
      byp = 1'b0;
      send(8'h81, 0, '0, 1'b0);
      send(8'hF0, 0, '0, 1'b0);
      drain();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/xor_descrambler.md
# xor_descrambler

Self-synchronous multiplicative descrambler that removes the XOR whitening applied by the link transmitter, with polynomial 1 + x^14 + x^15. It sits on the receive side between the deserializer and the framer and accepts one DATA_W-bit beat per cycle over a valid/ready stream. Output is a registered stage that reports when the descrambler state contains only received bits (locked). A sync-clear input forces resynchronization after a link drop.

## Interface
- DATA_W, default 8: bits per beat; must be ≥ 1. Bits are processed LSB first (bit 0 is the earliest on the wire).
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high reset.
- sync_clear  input  1  single-cycle synchronous request to clear the descrambler state and the lock counter.
- in_data  input  DATA_W  scrambled beat.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a beat. Equal to !sync_clear && (!out_valid || out_ready).
- out_data  output  DATA_W  descrambled beat, registered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_locked  output  1  sideband qualified by out_valid. High when the beat was descrambled with a fully received 15-bit history.

## Operation
- State:
  - s[14:0]: s[0] holds the most recently received scrambled bit.
  - cnt: saturating count of absorbed bits, saturates at 15, width 4 bits.
- Per input bit c, processed in order from bit 0 to bit DATA_W-1 within the same cycle:
  - d = c ^ s[13] ^ s[14]
  - s = {s[13:0], c}
  - Later bits of the same beat use the state already updated by earlier bits.
  - Equivalent form: d[k] = c[k] ^ c[k-14] ^ c[k-15] over the bit stream.
- Acceptance happens when in_valid && in_ready. On acceptance:
  - out_data receives the d bits.
  - out_locked receives (cnt == 15), using the value sampled before the beat.
  - s is updated.
  - cnt becomes min(15, cnt + DATA_W).
  - out_valid is set to 1.
- If out_valid && out_ready and no new acceptance occurs, out_valid clears. Accept and drain in the same cycle is allowed, giving full throughput.
- Output registers hold stable while out_valid && !out_ready.
- sync_clear:
  - Next edge: s = 0 and cnt = 0.
  - in_ready is forced low, so no beat is accepted in that cycle.
  - A beat already in the output register is unaffected and keeps its out_locked value.
- Beats are never dropped or duplicated. The unlocked beats emitted after a reset or a clear are still delivered, tagged out_locked = 0.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_locked = 0, s = 0, cnt = 0. in_ready = 1 after reset when sync_clear = 0.
- Latency: one cycle from acceptance to out_valid.
- Throughput: one beat per cycle when out_ready is held high.
- in_ready has a combinational path from out_ready and sync_clear. No other combinational input-to-output paths exist.
- Reset asserted mid-stream: all state clears immediately, and any pending output beat is discarded.
- First locked beat: the first beat accepted once cnt reaches 15. For DATA_W = 8 that is the 3rd beat; for DATA_W ≥ 15 it is the 2nd beat.

## Configuration
- Macro: XOR_DESCRAMBLER_BYPASS_EN.
- When the macro is defined:
  - An extra port is added: bypass  input  1.
  - When bypass = 1 at acceptance, out_data = in_data unchanged and out_locked = 1.
  - s and cnt still update as normal, so lock is preserved when bypass is dropped.
- When the macro is undefined, the port does not exist and the block always descrambles.

## Test plan
- Zero-history passthrough (DATA_W=8): after reset, accept 8'h01, then 8'h00, then 8'h00. Required outputs are 8'h01, 8'hC0, 8'h00, with out_locked 0, 0, 1.
- Round trip: drive 1000 random beats through a reference scrambler with the same polynomial and a random seed. After the first two beats, out_data must equal the original payload with out_locked = 1.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1. Required: in_ready = 0 after the first accept, out_data stable, and no beats lost. On release, output resumes one beat per cycle.
- sync_clear mid-stream: pulse sync_clear while in_valid = 1. Required: that cycle is not accepted, and the next two beats carry out_locked = 0 with history zeroed (the 8'h01 then 8'hC0 pattern repeats).
- Async reset while out_valid = 1 and out_ready = 0: out_valid drops without waiting for a clock edge, and all outputs return to their reset values.
- Bypass (with macro defined): bypass = 1 and in_data = 8'hA5 give out_data = 8'hA5 and out_locked = 1. After 2 beats, drop bypass; descrambling must be correct immediately.
